fact_unit: RTL and testbench

FACT_UNIT -- requirements
Module: fact_unit

---
 rtl/fact_unit.sv | 89 ++++++++
 tb/tb_fact_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fact_unit.sv
// Memory-mapped factorial accelerator: write N, pulse GO, poll STATUS, read RESULT.
// One multiply per clock; N above 12 overflows 32 bits and is rejected with err.
module fact_unit #(
  parameter int w = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         WE,
  input  logic [1:0]   A,
  input  logic [w-1:0] WD,
  output logic [w-1:0] RD
);

  localparam int unsigned NW = 4;
  localparam logic [NW-1:0] NMAX = NW'(12);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t         state;
  logic [NW-1:0]  n;
  logic [NW-1:0]  count;
  logic [w-1:0]   product;
  logic [w-1:0]   result;
  logic           done;
  logic           err;
  logic           busy;
  logic           start;
  logic           unused_wd;

  assign busy      = (state == COMPUTE);
  assign start     = WE && (A == 2'b01) && WD[0] && (state != COMPUTE);
  assign unused_wd = ^WD[w-1:NW];

  // Register file and FSM; count is captured at start so later N writes cannot disturb a run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      count   <= '0;
      product <= '0;
      result  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (WE && (A == 2'b00)) n <= WD[NW-1:0];
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (n > NMAX) begin
              state  <= DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
            end else begin
              state   <= COMPUTE;
              count   <= n;
              product <= w'(1);
              done    <= 1'b0;
              err     <= 1'b0;
            end
          end
        end
        COMPUTE: begin
          if (count > NW'(1)) begin
            product <= product * w'(count);
            count   <= count - NW'(1);
          end else begin
            state  <= DONE;
            done   <= 1'b1;
            result <= product;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Zero-latency read mux.
  always_comb begin
    RD = '0;
    case (A)
      2'b00:   RD = w'(n);
      2'b01:   RD = w'(busy);
      2'b10:   RD = w'({err, done});
      default: RD = result;
    endcase
  end

endmodule

// File: tb/tb_fact_unit.sv
// Directed bench for fact_unit: table of N values with hand-computed results and latencies,
// followed by sequences for ignored writes, mid-run reset and reset priority.
module tb_fact_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WE  = 1'b0;
  logic [1:0]  A   = 2'b00;
  logic [31:0] WD  = '0;
  logic [31:0] RD;

  int vectors = 0;
  int miscompares = 0;

  fact_unit #(.w(32)) dut (
    .clk(clk), .rst(rst), .WE(WE), .A(A), .WD(WD), .RD(RD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  n;
    int          lat;
    logic [31:0] res;
    logic [31:0] status;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Write spans exactly one rising edge; returns at the negedge after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    WE = 1'b1; A = a; WD = d;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    A = a;
    #1;
    d = RD;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0] = '{4'd0,  1, 32'd1,         32'h1};
    tbl[1] = '{4'd1,  1, 32'd1,         32'h1};
    tbl[2] = '{4'd2,  2, 32'd2,         32'h1};
    tbl[3] = '{4'd3,  3, 32'd6,         32'h1};
    tbl[4] = '{4'd5,  5, 32'd120,       32'h1};
    tbl[5] = '{4'd7,  7, 32'd5040,      32'h1};
    tbl[6] = '{4'd12, 12, 32'h1C8CFC00, 32'h1};
    tbl[7] = '{4'd13, 1, 32'd0,         32'h3};
    tbl[8] = '{4'd15, 1, 32'd0,         32'h3};
    tbl[9] = '{4'd4,  4, 32'd24,        32'h1};

    do_reset();
    chk_reg("reset_n", 2'b00, 32'h0);
    chk_reg("reset_busy", 2'b01, 32'h0);
    chk_reg("reset_status", 2'b10, 32'h0);
    chk_reg("reset_result", 2'b11, 32'h0);

    for (int i = 0; i < 10; i++) begin
      wr(2'b00, 32'hFFFF_FFF0 | 32'(tbl[i].n));
      chk_reg("n_readback", 2'b00, 32'(tbl[i].n));
      wr(2'b01, 32'h1);
      chk_reg("busy_after_start", 2'b01, (tbl[i].status == 32'h3) ? 32'h0 : 32'h1);
      for (int e = 1; e <= tbl[i].lat; e++) begin
        @(negedge clk);
        if (e < tbl[i].lat) chk_reg("status_pending", 2'b10, 32'h0);
      end
      chk_reg("status_final", 2'b10, tbl[i].status);
      chk_reg("result", 2'b11, tbl[i].res);
      chk_reg("busy_final", 2'b01, 32'h0);
    end

    // Start from an err DONE clears done/err at the start edge.
    wr(2'b00, 32'd13);
    wr(2'b01, 32'h1);
    chk_reg("err_status", 2'b10, 32'h3);
    wr(2'b00, 32'd3);
    wr(2'b01, 32'h1);
    chk_reg("restart_clears", 2'b10, 32'h0);
    chk_reg("restart_busy", 2'b01, 32'h1);
    repeat (3) @(negedge clk);
    chk_reg("restart_result", 2'b11, 32'd6);

    // N and GO writes during COMPUTE are ignored by the running computation.
    wr(2'b00, 32'd6);
    wr(2'b01, 32'h1);
    @(negedge clk);
    WE = 1'b1; A = 2'b00; WD = 32'd3;
    @(negedge clk);
    A = 2'b01; WD = 32'h1;
    @(negedge clk);
    WE = 1'b0;
    chk_reg("busy_mid_run", 2'b01, 32'h1);
    repeat (2) @(negedge clk);
    chk_reg("not_done_edge5", 2'b10, 32'h0);
    @(negedge clk);
    chk_reg("done_edge6", 2'b10, 32'h1);
    chk_reg("result_720", 2'b11, 32'd720);
    chk_reg("n_is_3", 2'b00, 32'd3);

    // GO with WD[0]=0 and writes to read-only registers change nothing.
    wr(2'b01, 32'hFFFF_FFFE);
    chk_reg("go0_status", 2'b10, 32'h1);
    chk_reg("go0_busy", 2'b01, 32'h0);
    wr(2'b10, 32'h0);
    wr(2'b11, 32'h0);
    chk_reg("ro_status", 2'b10, 32'h1);
    chk_reg("ro_result", 2'b11, 32'd720);
    repeat (4) @(negedge clk);
    chk_reg("hold_result", 2'b11, 32'd720);

    // Reset in the middle of a run aborts it with no later done.
    wr(2'b00, 32'd10);
    wr(2'b01, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reg("abort_n", 2'b00, 32'h0);
    chk_reg("abort_busy", 2'b01, 32'h0);
    chk_reg("abort_status", 2'b10, 32'h0);
    chk_reg("abort_result", 2'b11, 32'h0);
    repeat (12) @(negedge clk);
    chk_reg("no_done_after_abort", 2'b10, 32'h0);
    wr(2'b00, 32'd4);
    wr(2'b01, 32'h1);
    repeat (4) @(negedge clk);
    chk_reg("post_abort_status", 2'b10, 32'h1);
    chk_reg("post_abort_result", 2'b11, 32'd24);

    // Reset wins over a simultaneous start.
    wr(2'b00, 32'd5);
    @(negedge clk);
    rst = 1'b1; WE = 1'b1; A = 2'b01; WD = 32'h1;
    @(negedge clk);
    rst = 1'b0; WE = 1'b0;
    chk_reg("rst_prio_busy", 2'b01, 32'h0);
    chk_reg("rst_prio_n", 2'b00, 32'h0);
    chk_reg("rst_prio_result", 2'b11, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
